// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 DIT FFT sequencing logic.
package fft_pkg;

  localparam int unsigned LOG2N_DEFAULT = 4;
  localparam int unsigned N_DEFAULT     = 1 << LOG2N_DEFAULT;
  localparam int unsigned HALF_N_DEFAULT = N_DEFAULT / 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  // Stage counter width; never allowed to collapse to zero bits.
  function automatic int unsigned stage_width(input int unsigned log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

  localparam int unsigned STAGE_W_DEFAULT = stage_width(LOG2N_DEFAULT);

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, k) -> read pair and twiddle index.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = LOG2N_DEFAULT,
  parameter int unsigned SW    = stage_width(LOG2N)
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] twiddle_index
);

  localparam int unsigned  KW      = LOG2N - 1;
  localparam logic [SW:0]  TW_BASE = (SW+1)'(LOG2N - 1);

  logic [KW-1:0]    mask_s;
  logic [KW-1:0]    pos_s;
  logic [KW-1:0]    grp_s;
  logic [LOG2N-1:0] span_s;
  logic [SW:0]      grp_shift_s;
  logic [SW:0]      tw_shift_s;

  // Split k into position-within-group and group index, then interleave a zero bit at position s.
  always_comb begin
    mask_s        = ~({KW{1'b1}} << stage);
    pos_s         = k & mask_s;
    grp_s         = k >> stage;
    span_s        = {{(LOG2N-1){1'b0}}, 1'b1} << stage;
    grp_shift_s   = {1'b0, stage} + {{SW{1'b0}}, 1'b1};
    tw_shift_s    = TW_BASE - {1'b0, stage};
    addr_a        = ({1'b0, grp_s} << grp_shift_s) | {1'b0, pos_s};
    addr_b        = addr_a + span_s;
    twiddle_index = pos_s << tw_shift_s;
  end

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT: issues reads, twiddle
// indices and one-cycle-delayed write-backs.
module fft_butterfly_scheduler
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = LOG2N_DEFAULT
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [LOG2N-1:0]                rd_addr_a,
  output logic [LOG2N-1:0]                rd_addr_b,
  output logic [LOG2N-2:0]                twiddle_index,
  output logic                            wr_en,
  output logic [LOG2N-1:0]                wr_addr_a,
  output logic [LOG2N-1:0]                wr_addr_b,
  output logic [stage_width(LOG2N)-1:0]   stage
);

  localparam int unsigned     SW         = stage_width(LOG2N);
  localparam int unsigned     KW         = LOG2N - 1;
  localparam logic [KW-1:0]   K_LAST     = {KW{1'b1}};
  localparam logic [SW-1:0]   LAST_STAGE = SW'(LOG2N - 1);

  sched_state_t     state_r, next_state_s;
  logic [KW-1:0]    k_r, next_k_s;
  logic [SW-1:0]    stage_r, next_stage_s;
  logic [LOG2N-1:0] addr_a_s, addr_b_s;
  logic [KW-1:0]    tw_s;

  logic             busy_r, done_r, rd_en_r, wr_en_r;
  logic [LOG2N-1:0] rd_addr_a_r, rd_addr_b_r, wr_addr_a_r, wr_addr_b_r;
  logic [KW-1:0]    twiddle_r;

  // Addresses are generated from the next (stage, k) so the read strobe and its addresses leave flops together.
  fft_addr_gen #(.LOG2N(LOG2N), .SW(SW)) u_addr_gen (
    .stage         (next_stage_s),
    .k             (next_k_s),
    .addr_a        (addr_a_s),
    .addr_b        (addr_b_s),
    .twiddle_index (tw_s)
  );

  // Next-state and counter logic; abort overrides everything including start.
  always_comb begin
    next_state_s = state_r;
    next_k_s     = k_r;
    next_stage_s = stage_r;
    if (abort) begin
      next_state_s = ST_IDLE;
      next_k_s     = {KW{1'b0}};
      next_stage_s = {SW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          next_k_s     = {KW{1'b0}};
          next_stage_s = {SW{1'b0}};
          if (start) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (k_r == K_LAST) begin
            next_k_s     = {KW{1'b0}};
            next_state_s = (stage_r == LAST_STAGE) ? ST_DRAIN : ST_GAP;
          end else begin
            next_k_s     = k_r + KW'(1);
          end
        end
        ST_GAP: begin
          next_state_s = ST_RUN;
          next_k_s     = {KW{1'b0}};
          next_stage_s = stage_r + SW'(1);
        end
        ST_DRAIN: next_state_s = ST_DONE;
        ST_DONE: begin
          next_state_s = ST_IDLE;
          next_stage_s = {SW{1'b0}};
        end
        default: begin
          next_state_s = ST_IDLE;
          next_k_s     = {KW{1'b0}};
          next_stage_s = {SW{1'b0}};
        end
      endcase
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
      k_r     <= {KW{1'b0}};
      stage_r <= {SW{1'b0}};
    end else begin
      state_r <= next_state_s;
      k_r     <= next_k_s;
      stage_r <= next_stage_s;
    end
  end

  // Registered outputs; the write side trails the read side by one cycle and drops a write pending at abort.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_a_r <= {LOG2N{1'b0}};
      rd_addr_b_r <= {LOG2N{1'b0}};
      twiddle_r   <= {KW{1'b0}};
      wr_en_r     <= 1'b0;
      wr_addr_a_r <= {LOG2N{1'b0}};
      wr_addr_b_r <= {LOG2N{1'b0}};
    end else begin
      busy_r      <= (next_state_s != ST_IDLE);
      done_r      <= (next_state_s == ST_DONE);
      rd_en_r     <= (next_state_s == ST_RUN);
      rd_addr_a_r <= (next_state_s == ST_RUN) ? addr_a_s : {LOG2N{1'b0}};
      rd_addr_b_r <= (next_state_s == ST_RUN) ? addr_b_s : {LOG2N{1'b0}};
      twiddle_r   <= (next_state_s == ST_RUN) ? tw_s : {KW{1'b0}};
      wr_en_r     <= rd_en_r & ~abort;
      wr_addr_a_r <= rd_addr_a_r;
      wr_addr_b_r <= rd_addr_b_r;
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign rd_en         = rd_en_r;
  assign rd_addr_a     = rd_addr_a_r;
  assign rd_addr_b     = rd_addr_b_r;
  assign twiddle_index = twiddle_r;
  assign wr_en         = wr_en_r;
  assign wr_addr_a     = wr_addr_a_r;
  assign wr_addr_b     = wr_addr_b_r;
  assign stage         = stage_r;

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Scoreboard bench for fft_butterfly_scheduler with N=16 and N=8 instances.
module tb_fft_butterfly_scheduler;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, start3 = 1'b0, abort3 = 1'b0;

  logic       busy4, done4, rd_en4, wr_en4;
  logic [3:0] ra4, rb4, wa4, wb4;
  logic [2:0] tw4;
  logic [1:0] st4;

  logic       busy3, done3, rd_en3, wr_en3;
  logic [2:0] ra3, rb3, wa3, wb3;
  logic [1:0] tw3;
  logic [1:0] st3;

  typedef struct {int cyc; int a; int b; int tw; int st;} op_t;
  op_t rq4[$], wq4[$], rq3[$], wq3[$];
  int  dq4[$], dq3[$];
  int  blo[2] = '{1, 1};
  int  bhi[2] = '{0, 0};

  int cyc_cnt = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int base;

  fft_butterfly_scheduler #(.LOG2N(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .busy(busy4), .done(done4), .rd_en(rd_en4),
    .rd_addr_a(ra4), .rd_addr_b(rb4), .twiddle_index(tw4),
    .wr_en(wr_en4), .wr_addr_a(wa4), .wr_addr_b(wb4), .stage(st4)
  );

  fft_butterfly_scheduler #(.LOG2N(3)) dut3 (
    .clk(clk), .n_rst(n_rst), .start(start3), .abort(abort3),
    .busy(busy3), .done(done3), .rd_en(rd_en3),
    .rd_addr_a(ra3), .rd_addr_b(rb3), .twiddle_index(tw3),
    .wr_en(wr_en3), .wr_addr_a(wa3), .wr_addr_b(wb3), .stage(st3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0d, expected %0d (cycle count %0d)", tag, obs, exp, cyc_cnt);
    end
  endtask

  // Reference model: enumerate butterflies group by group, using div/mod arithmetic.
  task automatic push_run(input int inst, input int b0, input int l2n);
    int n2, span, pos, grp, dc;
    op_t r, w;
    n2 = (1 << l2n) / 2;
    for (int s = 0; s < l2n; s++) begin
      for (int k = 0; k < n2; k++) begin
        span  = 1 << s;
        pos   = k % span;
        grp   = k / span;
        r.cyc = b0 + 1 + s * (n2 + 1) + k;
        r.a   = grp * 2 * span + pos;
        r.b   = r.a + span;
        r.tw  = pos * (1 << (l2n - 1 - s));
        r.st  = s;
        w     = r;
        w.cyc = r.cyc + 1;
        if (inst == 0) begin rq4.push_back(r); wq4.push_back(w); end
        else begin rq3.push_back(r); wq3.push_back(w); end
      end
    end
    dc = b0 + l2n * n2 + (l2n - 1) + 2;
    if (inst == 0) dq4.push_back(dc); else dq3.push_back(dc);
    blo[inst] = b0 + 1;
    bhi[inst] = dc;
  endtask

  task automatic flush(input int lim);
    while (rq4.size() > 0 && rq4[rq4.size()-1].cyc > lim) rq4.delete(rq4.size()-1);
    while (wq4.size() > 0 && wq4[wq4.size()-1].cyc > lim) wq4.delete(wq4.size()-1);
    while (dq4.size() > 0 && dq4[dq4.size()-1] > lim) dq4.delete(dq4.size()-1);
    bhi[0] = lim;
  endtask

  task automatic mon(input int inst, input logic re, input int a, input int b, input int tw,
                     input int st, input logic we, input int wa, input int wb,
                     input logic dn, input logic bz);
    op_t   e;
    int    d;
    int    c = cyc_cnt;
    string p = (inst == 0) ? "n16_" : "n8_";
    if (re) begin
      if ((inst == 0 ? rq4.size() : rq3.size()) == 0) check_val({p, "rd_unexpected"}, 1, 0);
      else begin
        if (inst == 0) e = rq4.pop_front(); else e = rq3.pop_front();
        check_val({p, "rd_cycle"}, c, e.cyc);
        check_val({p, "rd_addr_a"}, a, e.a);
        check_val({p, "rd_addr_b"}, b, e.b);
        check_val({p, "twiddle"}, tw, e.tw);
        check_val({p, "stage"}, st, e.st);
      end
    end
    if (we) begin
      if ((inst == 0 ? wq4.size() : wq3.size()) == 0) check_val({p, "wr_unexpected"}, 1, 0);
      else begin
        if (inst == 0) e = wq4.pop_front(); else e = wq3.pop_front();
        check_val({p, "wr_cycle"}, c, e.cyc);
        check_val({p, "wr_addr_a"}, wa, e.a);
        check_val({p, "wr_addr_b"}, wb, e.b);
      end
    end
    if (dn) begin
      if ((inst == 0 ? dq4.size() : dq3.size()) == 0) check_val({p, "done_unexpected"}, 1, 0);
      else begin
        if (inst == 0) d = dq4.pop_front(); else d = dq3.pop_front();
        check_val({p, "done_cycle"}, c, d);
      end
    end
    check_val({p, "busy"}, bz, (c >= blo[inst] && c <= bhi[inst]) ? 1 : 0);
  endtask

  always @(negedge clk) mon(0, rd_en4, ra4, rb4, tw4, st4, wr_en4, wa4, wb4, done4, busy4);
  always @(negedge clk) mon(1, rd_en3, ra3, rb3, tw3, st3, wr_en3, wa3, wb3, done3, busy3);

  task automatic goto(input int t);
    while (cyc_cnt < t) @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string p);
    check_val({p, "_busy"}, busy4, 0);
    check_val({p, "_done"}, done4, 0);
    check_val({p, "_rd_en"}, rd_en4, 0);
    check_val({p, "_wr_en"}, wr_en4, 0);
    check_val({p, "_rd_addr_b"}, rb4, 0);
    check_val({p, "_wr_addr_b"}, wb4, 0);
    check_val({p, "_stage"}, st4, 0);
  endtask

  initial begin
    #1 n_rst = 1'b0;
    #1 check_all_zero("reset");
    goto(cyc_cnt + 2);
    n_rst = 1'b1;
    goto(cyc_cnt + 2);

    // Full N=16 run, with start pulses during RUN and DONE that must be ignored.
    base = cyc_cnt; push_run(0, base, 4);
    start = 1'b1; goto(base + 1); start = 1'b0;
    goto(base + 5);  start = 1'b1; goto(base + 6);  start = 1'b0;
    goto(base + 37); start = 1'b1; goto(base + 38); start = 1'b0;
    goto(base + 41);
    check_val("t1_idle_after_done", busy4, 0);

    // Abort in cycle 12.
    base = cyc_cnt; push_run(0, base, 4);
    start = 1'b1; goto(base + 1); start = 1'b0;
    goto(base + 12); abort = 1'b1; flush(base + 12);
    goto(base + 13); abort = 1'b0;
    check_val("abort_busy_c13", busy4, 0);
    goto(base + 20);

    // Abort and start together in IDLE: abort wins.
    base = cyc_cnt; start = 1'b1; abort = 1'b1;
    goto(base + 1); start = 1'b0; abort = 1'b0;
    goto(base + 4);
    check_val("abort_prio_busy", busy4, 0);

    // Clean run with start held high: second transform from cycle 39.
    base = cyc_cnt; push_run(0, base, 4);
    start = 1'b1;
    goto(base + 38); push_run(0, base + 38, 4);
    goto(base + 39); start = 1'b0;
    goto(base + 38 + 41);

    // Asynchronous reset mid-run, then a fresh run from stage 0.
    base = cyc_cnt; push_run(0, base, 4);
    start = 1'b1; goto(base + 1); start = 1'b0;
    goto(base + 20); n_rst = 1'b0; flush(base + 20);
    #1 check_all_zero("midrst");
    goto(base + 22); n_rst = 1'b1;
    goto(base + 24);
    base = cyc_cnt; push_run(0, base, 4);
    start = 1'b1; goto(base + 1); start = 1'b0;
    goto(base + 41);

    // LOG2N=3 instance: done in cycle 16.
    base = cyc_cnt; push_run(1, base, 3);
    start3 = 1'b1; goto(base + 1); start3 = 1'b0;
    goto(base + 20);

    check_val("n16_rd_queue_empty", rq4.size(), 0);
    check_val("n16_wr_queue_empty", wq4.size(), 0);
    check_val("n16_done_queue_empty", dq4.size(), 0);
    check_val("n8_rd_queue_empty", rq3.size(), 0);
    check_val("n8_wr_queue_empty", wq3.size(), 0);
    check_val("n8_done_queue_empty", dq3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
